generic_sram_burst_master: RTL and testbench

GENERIC_SRAM_BURST_MASTER -- requirements
Module: generic_sram_burst_master

---
 rtl/generic_sram_burst_master_if.sv | 46 ++++
 rtl/generic_sram_burst_master.sv | 184 ++++++++++++++++++
 tb/tb_generic_sram_burst_master.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/generic_sram_burst_master_if.sv
// Bus bundle for the SRAM burst master: command, write-beat and read-response
// handshakes, plus the single-port SRAM pins.
interface generic_sram_burst_master_if #(
    parameter int unsigned NUM_ADDR_BITS = 32,
    parameter int unsigned NUM_DATA_BITS = 32,
    parameter int unsigned NUM_LEN_BITS  = 4
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [NUM_ADDR_BITS-1:0]   cmd_addr;
    logic                       cmd_rnw;
    logic [NUM_LEN_BITS-1:0]    cmd_len;

    logic                       wr_valid;
    logic                       wr_ready;
    logic [NUM_DATA_BITS-1:0]   wr_data;
    logic [NUM_DATA_BITS/8-1:0] wr_strb;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [NUM_DATA_BITS-1:0]   rsp_data;
    logic                       rsp_last;

    logic [NUM_ADDR_BITS-1:0]   addr;
    logic [NUM_DATA_BITS-1:0]   write_data;
    logic [NUM_DATA_BITS/8-1:0] byte_en;
    logic                       write_en;
    logic                       read_en;
    logic [NUM_DATA_BITS-1:0]   read_data;

    modport master (
        input  cmd_valid, cmd_addr, cmd_rnw, cmd_len,
        input  wr_valid, wr_data, wr_strb,
        input  rsp_ready, read_data,
        output cmd_ready, wr_ready, rsp_valid, rsp_data, rsp_last,
        output addr, write_data, byte_en, write_en, read_en
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_rnw, cmd_len,
        output wr_valid, wr_data, wr_strb,
        output rsp_ready, read_data,
        input  cmd_ready, wr_ready, rsp_valid, rsp_data, rsp_last,
        input  addr, write_data, byte_en, write_en, read_en
    );
endinterface

// File: rtl/generic_sram_burst_master.sv
// Burst master for a single-port synchronous SRAM: turns burst commands into
// per-beat write_en/read_en cycles and buffers read data in a small response FIFO.
module generic_sram_burst_master #(
    parameter int unsigned NUM_ADDR_BITS  = 32,
    parameter int unsigned NUM_DATA_BITS  = 32,
    parameter int unsigned NUM_LEN_BITS   = 4,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input logic                         clock,
    input logic                         reset,
    generic_sram_burst_master_if.master bus
);
    localparam int unsigned NUM_STRB_BITS = NUM_DATA_BITS / 8;
    localparam int unsigned BEAT_W        = NUM_LEN_BITS + 1;
    localparam int unsigned PTR_W         = $clog2(RSP_FIFO_DEPTH);
    localparam int unsigned CNT_W         = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    typedef struct packed {
        logic                     last;
        logic [NUM_DATA_BITS-1:0] data;
    } rsp_entry_t;

    state_e                   state_q, state_d;
    logic [NUM_ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
    logic [BEAT_W-1:0]        beats_q, beats_d;
    // Beats issued but not yet popped: covers the latency pipe and the FIFO.
    logic [CNT_W-1:0]         used_q, used_d;

    logic                     write_en_q, write_en_d;
    logic                     read_en_q, read_en_d;
    logic                     read_last_q, read_last_d;
    logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [NUM_DATA_BITS-1:0] write_data_q, write_data_d;
    logic [NUM_STRB_BITS-1:0] byte_en_q, byte_en_d;

    logic [READ_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0]  pipe_last_q, pipe_last_d;

    rsp_entry_t               mem_q [RSP_FIFO_DEPTH];
    rsp_entry_t               mem_d [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic issue, push, pop, fifo_nonempty;

    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty && bus.rsp_ready;
    assign push          = pipe_vld_q[READ_LATENCY-1];

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_d      = beats_q;
        write_en_d   = 1'b0;
        read_en_d    = 1'b0;
        read_last_d  = 1'b0;
        addr_d       = '0;
        write_data_d = '0;
        byte_en_d    = '0;
        issue        = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    cur_addr_d = bus.cmd_addr;
                    beats_d    = {1'b0, bus.cmd_len} + BEAT_W'(1);
                    state_d    = bus.cmd_rnw ? StRead : StWrite;
                end
            end
            StWrite: begin
                if (bus.wr_valid) begin
                    write_en_d   = 1'b1;
                    addr_d       = cur_addr_q;
                    write_data_d = bus.wr_data;
                    byte_en_d    = bus.wr_strb;
                    cur_addr_d   = cur_addr_q + NUM_ADDR_BITS'(1);
                    beats_d      = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) state_d = StIdle;
                end
            end
            StRead: begin
                if (used_q < CNT_W'(RSP_FIFO_DEPTH)) begin
                    issue       = 1'b1;
                    read_en_d   = 1'b1;
                    read_last_d = (beats_q == BEAT_W'(1));
                    addr_d      = cur_addr_q;
                    byte_en_d   = '1;
                    cur_addr_d  = cur_addr_q + NUM_ADDR_BITS'(1);
                    beats_d     = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_last_d    = '0;
        pipe_vld_d[0]  = read_en_q;
        pipe_last_d[0] = read_last_q;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = '{last: pipe_last_q[READ_LATENCY-1], data: bus.read_data};
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop) rptr_d = rptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case ({issue, pop})
            2'b10:   used_d = used_q + CNT_W'(1);
            2'b01:   used_d = used_q - CNT_W'(1);
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            beats_q      <= '0;
            used_q       <= '0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            read_last_q  <= 1'b0;
            addr_q       <= '0;
            write_data_q <= '0;
            byte_en_q    <= '0;
            pipe_vld_q   <= '0;
            pipe_last_q  <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_q      <= beats_d;
            used_q       <= used_d;
            write_en_q   <= write_en_d;
            read_en_q    <= read_en_d;
            read_last_q  <= read_last_d;
            addr_q       <= addr_d;
            write_data_q <= write_data_d;
            byte_en_q    <= byte_en_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_last_q  <= pipe_last_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Outputs are forced low while reset is high, even before the reset edge.
    assign bus.cmd_ready  = (state_q == StIdle) && !reset;
    assign bus.wr_ready   = (state_q == StWrite) && !reset;
    assign bus.rsp_valid  = fifo_nonempty && !reset;
    assign bus.rsp_data   = mem_q[rptr_q].data;
    assign bus.rsp_last   = fifo_nonempty && !reset && mem_q[rptr_q].last;
    assign bus.write_en   = write_en_q && !reset;
    assign bus.read_en    = read_en_q && !reset;
    assign bus.addr       = reset ? '0 : addr_q;
    assign bus.write_data = reset ? '0 : write_data_q;
    assign bus.byte_en    = reset ? '0 : byte_en_q;
endmodule

// File: tb/tb_generic_sram_burst_master.sv
// Scoreboard bench for generic_sram_burst_master: stimulus pushes expected SRAM
// operations and responses; a negedge monitor pops and compares.
module tb_generic_sram_burst_master;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    generic_sram_burst_master_if #(
        .NUM_ADDR_BITS(32), .NUM_DATA_BITS(32), .NUM_LEN_BITS(4)
    ) bus ();

    generic_sram_burst_master #(
        .NUM_ADDR_BITS(32), .NUM_DATA_BITS(32), .NUM_LEN_BITS(4),
        .READ_LATENCY(2), .RSP_FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sram_op_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rsp_t;

    sram_op_t exp_sram[$];
    rsp_t     exp_rsp[$];
    int n_checks = 0;
    int n_errors = 0;
    int rd_count = 0;
    int wr_count = 0;
    int rsp_seen = 0;

    // SRAM read data pattern, distinct per address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h3C3C, ~a[15:0]};
    endfunction

    // Two-stage SRAM read pipe: read_en seen at edge t gives read_data in cycle t+2.
    logic [31:0] sram_p1;
    always @(posedge clock) begin
        sram_p1       <= bus.read_en ? mem_val(bus.addr) : 32'hDEAD_BEEF;
        bus.read_data <= sram_p1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        sram_op_t op;
        rsp_t     r;
        chk("we_re_exclusive", 64'(bus.write_en & bus.read_en), 64'd0);
        if (bus.write_en || bus.read_en) begin
            if (bus.read_en) rd_count++;
            if (bus.write_en) wr_count++;
            if (exp_sram.size() == 0) begin
                chk("unexpected_sram_op", 64'(bus.addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                op = exp_sram.pop_front();
                chk("sram_we", 64'(bus.write_en), 64'(op.we));
                chk("sram_addr", 64'(bus.addr), 64'(op.addr));
                chk("sram_be", 64'(bus.byte_en), 64'(op.be));
                if (op.we) chk("sram_wdata", 64'(bus.write_data), 64'(op.data));
            end
        end else begin
            chk("idle_addr_zero", 64'(bus.addr), 64'd0);
            chk("idle_wdata_zero", 64'(bus.write_data), 64'd0);
            chk("idle_be_zero", 64'(bus.byte_en), 64'd0);
        end
        if (bus.rsp_valid) rsp_seen++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp", 64'(bus.rsp_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                r = exp_rsp.pop_front();
                chk("rsp_data", 64'(bus.rsp_data), 64'(r.data));
                chk("rsp_last", 64'(bus.rsp_last), 64'(r.last));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
        chk({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_last"}, 64'(bus.rsp_last), 64'd0);
        chk({tag, "_write_en"}, 64'(bus.write_en), 64'd0);
        chk({tag, "_read_en"}, 64'(bus.read_en), 64'd0);
        chk({tag, "_addr"}, 64'(bus.addr), 64'd0);
        chk({tag, "_write_data"}, 64'(bus.write_data), 64'd0);
        chk({tag, "_byte_en"}, 64'(bus.byte_en), 64'd0);
    endtask

    // Called and returns at posedge+#1.
    task automatic send_cmd(input logic rnw, input logic [31:0] a, input logic [3:0] len);
        bit ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_rnw   = rnw;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_accept_timeout", 64'(ok), 64'd1);
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_rnw   = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] a_exp, input logic [31:0] d,
                             input logic [3:0] s);
        bit ok = 1'b0;
        exp_sram.push_back('{we: 1'b1, addr: a_exp, data: d, be: s});
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_strb  = s;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (bus.wr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wr_accept_timeout", 64'(ok), 64'd1);
        @(posedge clock); #1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_strb  = '0;
    endtask

    task automatic read_burst(input logic [31:0] a, input logic [3:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            exp_sram.push_back('{we: 1'b0, addr: a + 32'(i), data: 32'd0, be: 4'hF});
            exp_rsp.push_back('{data: mem_val(a + 32'(i)), last: (i == int'(len))});
        end
        send_cmd(1'b1, a, len);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clock); #1;
            if (exp_sram.size() == 0 && exp_rsp.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", 64'(ok), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int base;
        int base_wr;
        bit ok;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_rnw = 1'b0; bus.cmd_len = '0;
        bus.wr_valid  = 1'b0; bus.wr_data  = '0; bus.wr_strb = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        @(negedge clock); chk_all_zero("rst");
        @(negedge clock); chk_all_zero("rst2");
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);
        @(posedge clock); #1;

        // Single-beat write
        send_cmd(1'b0, 32'h10, 4'd0);
        send_beat(32'h10, 32'hA5A5_A5A5, 4'hF);
        drain();

        // Four-beat read, consecutive read_en
        bus.rsp_ready = 1'b1;
        read_burst(32'h20, 4'd3);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.read_en) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        chk("rd_start_timeout", 64'(ok), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rd_consecutive", 64'(bus.read_en), 64'd1);
            @(posedge clock); #1;
        end
        chk("rd_stops", 64'(bus.read_en), 64'd0);
        drain();

        // Eight-beat read under full backpressure
        bus.rsp_ready = 1'b0;
        base = rd_count;
        read_burst(32'h40, 4'd7);
        idle(20);
        chk("rd_pulses_stalled", 64'(rd_count - base), 64'd4);
        chk("rsp_pending", 64'(exp_rsp.size()), 64'd8);
        bus.rsp_ready = 1'b1;
        drain();
        chk("rd_pulses_total", 64'(rd_count - base), 64'd8);

        // Two-beat write across the address wrap with a wr_valid gap
        base_wr = wr_count;
        send_cmd(1'b0, 32'hFFFF_FFFF, 4'd1);
        send_beat(32'hFFFF_FFFF, 32'h1234_5678, 4'h3);
        idle(3);
        chk("wr_gap_count", 64'(wr_count - base_wr), 64'd1);
        send_beat(32'h0000_0000, 32'h9ABC_DEF0, 4'hC);
        drain();
        chk("wr_wrap_count", 64'(wr_count - base_wr), 64'd2);

        // Reset during the second beat of a four-beat read
        base = rd_count;
        read_burst(32'h80, 4'd3);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clock); #1;
            if (rd_count == base + 1 && bus.read_en) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rd_second_beat_timeout", 64'(ok), 64'd1);
        reset = 1'b1;
        exp_sram.delete();
        exp_rsp.delete();
        @(negedge clock); chk_all_zero("midrst");
        @(posedge clock); #1;
        @(negedge clock); chk_all_zero("midrst_edge");
        @(posedge clock); #1;
        reset = 1'b0;
        base = rsp_seen;
        idle(10);
        chk("no_rsp_after_reset", 64'(rsp_seen - base), 64'd0);
        read_burst(32'h90, 4'd0);
        drain();

        // Back-to-back read then write
        base    = rd_count;
        base_wr = wr_count;
        read_burst(32'hA0, 4'd0);
        send_cmd(1'b0, 32'hB0, 4'd0);
        send_beat(32'hB0, 32'hCAFE_F00D, 4'hF);
        drain();
        chk("b2b_rd_count", 64'(rd_count - base), 64'd1);
        chk("b2b_wr_count", 64'(wr_count - base_wr), 64'd1);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
